// File: rtl/sykt_bus_bridge.sv
// sykt_bus_bridge: valid/ready request/response bus to the peripheral's
// edge-sampled saddress/srd/swr register-port protocol.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_we/req_addr/
//   req_wdata (request); resp_valid/resp_ready/resp_rdata/resp_err (response);
//   saddress/srd/swr/sdata_wr/sdata_rd (peripheral side).
// Optional feature: define SYKT_BRIDGE_ADDR_CHECK_EN to reject requests to
//   registers that are not legal for the access direction.
module sykt_bus_bridge #(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_wr,
   input  logic [31:0] sdata_rd
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RESP
   } state_t;

   localparam logic [3:0] S_LAST = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] T_LAST = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] H_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       we_q;
   logic       err_q;
   logic       req_legal;

`ifdef SYKT_BRIDGE_ADDR_CHECK_EN
   assign req_legal = req_we ? (req_addr == 16'h00C8)
                             : (req_addr == 16'h00C8 ||
                                req_addr == 16'h00D8 ||
                                req_addr == 16'h00E0);
`else
   assign req_legal = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         saddress   <= '0;
         sdata_wr   <= '0;
         srd        <= 1'b0;
         swr        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  we_q      <= req_we;
                  cnt       <= '0;
                  if (req_legal) begin
                     err_q    <= 1'b0;
                     saddress <= req_addr;
                     sdata_wr <= req_we ? req_wdata : 32'h0;
                     state    <= SETUP;
                  end else begin
                     // Rejected: skip the bus phases, spend one cycle
                     // in HOLD with saddress left untouched.
                     err_q <= 1'b1;
                     state <= HOLD;
                  end
               end
            end
            SETUP: begin
               if (cnt == S_LAST) begin
                  cnt   <= '0;
                  srd   <= ~we_q;
                  swr   <= we_q;
                  state <= STROBE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            STROBE: begin
               if (cnt == T_LAST) begin
                  cnt <= '0;
                  srd <= 1'b0;
                  swr <= 1'b0;
                  // Peripheral drove sdata_out on the srd rising edge,
                  // so at least one full cycle has passed here.
                  if (!we_q) resp_rdata <= sdata_rd;
                  state <= HOLD;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            HOLD: begin
               if (err_q || cnt == H_LAST) begin
                  cnt        <= '0;
                  resp_valid <= 1'b1;
                  resp_err   <= err_q;
                  state      <= RESP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  saddress   <= '0;
                  sdata_wr   <= '0;
                  err_q      <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sykt_bus_bridge.sv
// tb_sykt_bus_bridge: bench for sykt_bus_bridge, default timing (index 0)
// and SETUP=3/STROBE=1/HOLD=2 (index 1) instances side by side.
module tb_sykt_bus_bridge;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [15:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        resp_valid[2];
   logic        resp_ready[2];
   logic [31:0] resp_rdata[2];
   logic        resp_err  [2];
   logic [15:0] saddress  [2];
   logic        srd       [2];
   logic        swr       [2];
   logic [31:0] sdata_wr  [2];
   logic [31:0] sdata_rd  [2];

   int n_cmp = 0;
   int n_bad = 0;

   int st[2] = '{1, 3};
   int tt[2] = '{2, 1};
   int ht[2] = '{1, 2};

`ifdef SYKT_BRIDGE_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef logic [84:0] vec_t;
   localparam vec_t IDLE_V = {1'b1, 84'h0};
   localparam vec_t RESP_MASK = ~{5'h0, 16'hFFFF, 32'hFFFF_FFFF, 32'h0};

   sykt_bus_bridge dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
      .saddress(saddress[0]), .srd(srd[0]), .swr(swr[0]),
      .sdata_wr(sdata_wr[0]), .sdata_rd(sdata_rd[0])
   );

   sykt_bus_bridge #(
      .SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)
   ) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
      .saddress(saddress[1]), .srd(srd[1]), .swr(swr[1]),
      .sdata_wr(sdata_wr[1]), .sdata_rd(sdata_rd[1])
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit legal(bit we, logic [15:0] a);
      bit ok_w, ok_r;
      ok_w = (a == 16'h00C8);
      ok_r = (a == 16'h00C8) || (a == 16'h00D8) || (a == 16'h00E0);
      return !CHK || (we ? ok_w : ok_r);
   endfunction

   function automatic vec_t obs(int d);
      return {req_ready[d], resp_valid[d], resp_err[d], srd[d], swr[d],
              saddress[d], sdata_wr[d], resp_rdata[d]};
   endfunction

   task automatic do_txn(input int d, input bit we, input logic [15:0] addr,
                         input logic [31:0] wd, input logic [31:0] rnew,
                         input int bp, input bit keep, input bit imm,
                         input string nm);
      int w;
      bit ok;
      int s, t, h, lat;
      vec_t ev, m;
      ok  = legal(we, addr);
      s   = st[d];
      t   = tt[d];
      h   = ht[d];
      lat = ok ? s + t + h : 1;
      w   = 0;
      sdata_rd[d]  = 32'h0;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      req_valid[d] = 1'b1;
      while (req_ready[d] !== 1'b1 && w < 20) begin
         tick;
         w++;
      end
      n_cmp++;
      if (req_ready[d] !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready_timeout got %b want 1", nm, req_ready[d]);
         req_valid[d] = 1'b0;
         return;
      end
      if (imm) begin
         n_cmp++;
         if (w !== 0) begin
            n_bad++;
            $display("FAIL %s accept_wait got %0d want 0", nm, w);
         end
      end
      tick;
      req_valid[d] = keep;
      req_we[d]    = 1'($urandom);
      req_addr[d]  = 16'($urandom);
      req_wdata[d] = $urandom;
      for (int n = 0; n <= lat + bp; n++) begin
         ev = {1'b0,
               n >= lat,
               n >= lat && !ok,
               ok && !we && n >= s && n < s + t,
               ok && we && n >= s && n < s + t,
               ok ? addr : 16'h0,
               (ok && we) ? wd : 32'h0,
               (ok && !we && n >= s + t) ? rnew : 32'h0};
         m = (n >= lat) ? RESP_MASK : '1;
         n_cmp++;
         if ((obs(d) & m) !== (ev & m)) begin
            n_bad++;
            $display("FAIL %s cyc%0d got %h want %h", nm, n,
                     obs(d) & m, ev & m);
         end
         if (n == s && ok && !we) sdata_rd[d] = rnew;
         if (n == lat + bp) resp_ready[d] = 1'b1;
         tick;
      end
      resp_ready[d] = 1'b0;
      n_cmp++;
      if (obs(d) !== IDLE_V) begin
         n_bad++;
         $display("FAIL %s after_hs got %h want %h", nm, obs(d), IDLE_V);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (obs(d) !== '0) begin
            n_bad++;
            $display("FAIL reset_outs%0d got %h want 0", d, obs(d));
         end
      end
      reset = 1'b0;
      tick;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (obs(d) !== IDLE_V) begin
            n_bad++;
            $display("FAIL reset_rel%0d got %h want %h", d, obs(d), IDLE_V);
         end
      end
   endtask

   task automatic test_read_e0;
      do_txn(0, 1'b0, 16'h00E0, 32'h0, 32'h2, 0, 1'b0, 1'b0, "read_e0");
   endtask

   task automatic test_write_c8;
      do_txn(0, 1'b1, 16'h00C8, 32'hA, 32'h0, 1, 1'b0, 1'b0, "write_c8");
   endtask

   task automatic test_backpressure;
      do_txn(0, 1'b0, 16'h00D8, 32'h0, $urandom, 5, 1'b1, 1'b0, "bp_first");
      do_txn(0, 1'b1, 16'h00C8, $urandom, 32'h0, 0, 1'b0, 1'b1, "bp_second");
   endtask

   task automatic test_addr_check;
      do_txn(0, 1'b1, 16'h00D8, 32'h5, 32'h0, 0, 1'b0, 1'b0, "chk_wr_d8");
      do_txn(0, 1'b0, 16'h0010, 32'h0, 32'h77, 1, 1'b0, 1'b0, "chk_rd_10");
   endtask

   task automatic test_custom_timing;
      do_txn(1, 1'b0, 16'h00E0, 32'h0, $urandom, 0, 1'b0, 1'b0, "cust_rd");
      do_txn(1, 1'b1, 16'h00C8, $urandom, 32'h0, 2, 1'b0, 1'b0, "cust_wr");
   endtask

   task automatic test_reset_mid_strobe;
      bit seen_rv;
      seen_rv = 1'b0;
      req_we[0]    = 1'b1;
      req_addr[0]  = 16'h00C8;
      req_wdata[0] = 32'h1234_5678;
      req_valid[0] = 1'b1;
      tick;
      req_valid[0] = 1'b0;
      for (int i = 0; i < st[0]; i++) tick;
      n_cmp++;
      if (swr[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_strobe_pre got %b want 1", swr[0]);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      n_cmp++;
      if (obs(0) !== '0) begin
         n_bad++;
         $display("FAIL rst_strobe_outs got %h want 0", obs(0));
      end
      tick;
      n_cmp++;
      if (obs(0) !== IDLE_V) begin
         n_bad++;
         $display("FAIL rst_strobe_rel got %h want %h", obs(0), IDLE_V);
      end
      for (int i = 0; i < 6; i++) begin
         if (resp_valid[0] === 1'b1) seen_rv = 1'b1;
         tick;
      end
      n_cmp++;
      if (seen_rv !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_strobe_resp got %b want 0", seen_rv);
      end
   endtask

   task automatic test_random;
      int d;
      bit we, keep, imm;
      logic [15:0] a;
      int pick;
      d   = 0;
      imm = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!imm) d = int'($urandom_range(0, 1));
         we   = 1'($urandom);
         pick = int'($urandom_range(0, 3));
         a    = (pick == 0) ? 16'h00C8 : (pick == 1) ? 16'h00D8 :
                (pick == 2) ? 16'h00E0 : 16'($urandom);
         keep = (i < 19) ? 1'($urandom) : 1'b0;
         do_txn(d, we, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                keep, imm, "random");
         imm = keep;
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req_valid[d]  = 1'b0;
         req_we[d]     = 1'b0;
         req_addr[d]   = 16'h0;
         req_wdata[d]  = 32'h0;
         resp_ready[d] = 1'b0;
         sdata_rd[d]   = 32'h0;
      end
      reset = 1'b1;
      test_reset;
      test_read_e0;
      test_write_c8;
      test_backpressure;
      test_addr_check;
      test_custom_timing;
      test_reset_mid_strobe;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
